// File: rtl/dio_slot_arbiter_if.sv
// DIO slot bus between the requesters/address controller and the slot arbiter.
// The slave side is the arbiter; the master side is everything around it.
interface dio_slot_arbiter_if #(
   parameter int NREQ = 4,
   parameter int AW   = 22
) ();
   logic                 slot_en;
   logic [NREQ-1:0]      req;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*AW-1:0]   req_base;
   logic [15:0]          mem_din;
   logic [AW-1:0]        mem_addr;
   logic                 mem_rd;
   logic [NREQ-1:0]      ack;
   logic [15:0]          rdata;
   logic                 busy;
   logic [2:0]           grant_id;
   logic [7:0]           overrun_cnt;

   modport master (
      output slot_en, req, req_addr, req_base, mem_din,
      input  mem_addr, mem_rd, ack, rdata, busy, grant_id, overrun_cnt
   );

   modport slave (
      input  slot_en, req, req_addr, req_base, mem_din,
      output mem_addr, mem_rd, ack, rdata, busy, grant_id, overrun_cnt
   );
endinterface

// File: rtl/dio_slot_arbiter.sv
// Round-robin arbiter sharing the DIO memory slot among NREQ read requesters.
// One grant per slot: drive address/strobe, capture the word, ack the grantee.
module dio_slot_arbiter #(
   parameter int NREQ   = 4,
   parameter int AW     = 22,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   dio_slot_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   state_t                  state, nextState;
   logic [IW-1:0]           last;
   logic [IW-1:0]           selIdx;
   logic [CW-1:0]           latCnt;
   logic [NREQ-1:0][AW-1:0] reqSum;
   logic                    anyReq;
   logic                    grantEn, captureEn, slotMiss;

   // Per-requester image address; the sum wraps inside AW bits.
   for (genvar i = 0; i < NREQ; i++) begin : gSum
      assign reqSum[i] = bus.req_addr[i*AW +: AW] + bus.req_base[i*AW +: AW];
   end

   assign anyReq = |bus.req;

   // First pending requester searching upward from last+1, wrapping.
   always_comb begin
      int j;
      logic found;
      selIdx = '0;
      found  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(last) + 1 + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && bus.req[j]) begin
            selIdx = IW'(j);
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.slot_en && anyReq) nextState = ACCESS;
         ACCESS:  if (latCnt == CW'(1)) nextState = ACK;
         ACK:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      grantEn   = (state == IDLE) && bus.slot_en && anyReq;
      captureEn = (state == ACCESS) && (latCnt == CW'(1));
      slotMiss  = (state != IDLE) && bus.slot_en;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mem_addr    <= '0;
         bus.mem_rd      <= 1'b0;
         bus.ack         <= '0;
         bus.rdata       <= '0;
         bus.busy        <= 1'b0;
         bus.grant_id    <= '0;
         bus.overrun_cnt <= '0;
         last            <= IW'(NREQ - 1);
         latCnt          <= '0;
      end else begin
         bus.ack  <= '0;
         bus.busy <= (nextState != IDLE);
         if (grantEn) begin
            bus.mem_addr <= reqSum[selIdx];
            bus.mem_rd   <= 1'b1;
            bus.grant_id <= 3'(selIdx);
            last         <= selIdx;
            latCnt       <= CW'(RD_LAT);
         end else if (state == ACCESS) begin
            latCnt <= latCnt - CW'(1);
         end
         // A requester that withdrew mid-access still gets rdata but no ack.
         if (captureEn) begin
            bus.rdata  <= bus.mem_din;
            bus.mem_rd <= 1'b0;
            if (bus.req[last]) bus.ack <= NREQ'(1) << last;
         end
         if (slotMiss && bus.overrun_cnt != 8'hFF)
            bus.overrun_cnt <= bus.overrun_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_dio_slot_arbiter.sv
// Directed bench for dio_slot_arbiter: reset, round-robin, wrap, overrun,
// withdrawal and reset during an access.
module tb_dio_slot_arbiter;
   localparam int NREQ = 4;
   localparam int AW   = 22;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   dio_slot_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

   dio_slot_arbiter #(.NREQ(NREQ), .AW(AW), .RD_LAT(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a, input logic [AW-1:0] b);
      bus.req_addr[i*AW +: AW] = a;
      bus.req_base[i*AW +: AW] = b;
   endtask

   task automatic apply_reset();
      reset       = 1'b1;
      bus.slot_en = 1'b0;
      bus.req     = '0;
      bus.req_addr = '0;
      bus.req_base = '0;
      bus.mem_din = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if (bus.mem_addr !== 22'h0 || bus.mem_rd !== 1'b0 || bus.ack !== 4'h0 ||
          bus.rdata !== 16'h0 || bus.busy !== 1'b0 || bus.grant_id !== 3'd0 ||
          bus.overrun_cnt !== 8'h0) begin
         bad++;
         $display("FAIL reset_outputs got addr=%h rd=%b ack=%b rdata=%h busy=%b gid=%0d ovr=%0d exp all zero",
                  bus.mem_addr, bus.mem_rd, bus.ack, bus.rdata, bus.busy, bus.grant_id, bus.overrun_cnt);
      end
      bus.req = 4'b0001;
      set_addr(0, 22'h00010, 22'h100000);
      bus.slot_en = 1'b1;
      tick();
      bus.slot_en = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         total++;
         if (bus.mem_addr !== 22'h100010 || bus.mem_rd !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL first_access_T+%0d got addr=%h rd=%b busy=%b exp addr=100010 rd=1 busy=1",
                     c, bus.mem_addr, bus.mem_rd, bus.busy);
         end
         bus.mem_din = 16'hBEEF;
         tick();
      end
      total++;
      if (bus.ack !== 4'b0001 || bus.rdata !== 16'hBEEF || bus.mem_rd !== 1'b0) begin
         bad++;
         $display("FAIL first_ack got ack=%b rdata=%h rd=%b exp ack=0001 rdata=beef rd=0",
                  bus.ack, bus.rdata, bus.mem_rd);
      end
      tick();
      total++;
      if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL first_ack_end got ack=%b busy=%b exp ack=0000 busy=0", bus.ack, bus.busy);
      end
   endtask

   task automatic test_round_robin();
      logic [AW-1:0] addrTab [NREQ];
      logic [3:0]    expAck;
      int            g;
      apply_reset();
      for (int i = 0; i < NREQ; i++) begin
         addrTab[i] = 22'h000100 * (i + 1) + 22'h3;
         set_addr(i, addrTab[i], 22'h0);
      end
      bus.req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         g = k % NREQ;
         expAck = 4'b0001 << g;
         bus.slot_en = 1'b1;
         tick();
         bus.slot_en = 1'b0;
         total++;
         if (bus.grant_id !== 3'(g) || bus.mem_addr !== addrTab[g] || bus.mem_rd !== 1'b1) begin
            bad++;
            $display("FAIL rr_grant_%0d got gid=%0d addr=%h rd=%b exp gid=%0d addr=%h rd=1",
                     k, bus.grant_id, bus.mem_addr, bus.mem_rd, g, addrTab[g]);
         end
         bus.mem_din = 16'hA000 + 16'(k);
         tick();
         tick();
         total++;
         if (bus.ack !== expAck || bus.rdata !== 16'hA000 + 16'(k)) begin
            bad++;
            $display("FAIL rr_ack_%0d got ack=%b rdata=%h exp ack=%b rdata=%h",
                     k, bus.ack, bus.rdata, expAck, 16'hA000 + 16'(k));
         end
         tick();
         total++;
         if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_idle_%0d got ack=%b busy=%b exp ack=0000 busy=0", k, bus.ack, bus.busy);
         end
      end
      // Slots were spaced at the minimum legal interval, so none were lost.
      total++;
      if (bus.overrun_cnt !== 8'd0) begin
         bad++;
         $display("FAIL rr_no_overrun got ovr=%0d exp 0", bus.overrun_cnt);
      end
      bus.req = '0;
   endtask

   task automatic test_wrap();
      apply_reset();
      set_addr(0, 22'h000020, 22'h3FFFF0);
      bus.req = 4'b0001;
      bus.slot_en = 1'b1;
      tick();
      bus.slot_en = 1'b0;
      total++;
      if (bus.mem_addr !== 22'h000010) begin
         bad++;
         $display("FAIL wrap_addr got addr=%h exp 000010", bus.mem_addr);
      end
      tick();
      tick();
      tick();
      bus.req = '0;
   endtask

   task automatic test_overrun();
      apply_reset();
      set_addr(0, 22'h000055, 22'h0);
      bus.req = 4'b0001;
      for (int i = 0; i < 300; i++) begin
         bus.slot_en = 1'b1;
         tick();
         bus.slot_en = 1'b0;
         tick();
         bus.slot_en = 1'b1;
         tick();
         bus.slot_en = 1'b0;
         if (i == 0) begin
            total++;
            if (bus.overrun_cnt !== 8'd1 || bus.ack !== 4'b0001 || bus.grant_id !== 3'd0) begin
               bad++;
               $display("FAIL overrun_first got ovr=%0d ack=%b gid=%0d exp ovr=1 ack=0001 gid=0",
                        bus.overrun_cnt, bus.ack, bus.grant_id);
            end
         end
         tick();
      end
      total++;
      if (bus.overrun_cnt !== 8'd255) begin
         bad++;
         $display("FAIL overrun_saturate got ovr=%0d exp 255", bus.overrun_cnt);
      end
      bus.req = '0;
   endtask

   task automatic test_withdrawal();
      apply_reset();
      set_addr(0, 22'h000040, 22'h0);
      set_addr(1, 22'h000080, 22'h0);
      bus.req = 4'b0011;
      bus.slot_en = 1'b1;
      tick();
      bus.slot_en = 1'b0;
      tick();
      bus.req = 4'b0010;
      bus.mem_din = 16'h1234;
      tick();
      total++;
      if (bus.ack !== 4'b0000 || bus.rdata !== 16'h1234 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL withdraw_noack got ack=%b rdata=%h busy=%b exp ack=0000 rdata=1234 busy=1",
                  bus.ack, bus.rdata, bus.busy);
      end
      tick();
      bus.slot_en = 1'b1;
      tick();
      bus.slot_en = 1'b0;
      total++;
      if (bus.grant_id !== 3'd1 || bus.mem_addr !== 22'h000080) begin
         bad++;
         $display("FAIL withdraw_next got gid=%0d addr=%h exp gid=1 addr=000080",
                  bus.grant_id, bus.mem_addr);
      end
      bus.mem_din = 16'h5678;
      tick();
      tick();
      total++;
      if (bus.ack !== 4'b0010 || bus.rdata !== 16'h5678) begin
         bad++;
         $display("FAIL withdraw_next_ack got ack=%b rdata=%h exp ack=0010 rdata=5678",
                  bus.ack, bus.rdata);
      end
      tick();
      bus.req = '0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] ackSeen;
      apply_reset();
      bus.req = 4'b1111;
      bus.mem_din = 16'hCAFE;
      bus.slot_en = 1'b1;
      tick();
      bus.slot_en = 1'b0;
      total++;
      if (bus.grant_id !== 3'd0 || bus.mem_rd !== 1'b1) begin
         bad++;
         $display("FAIL midrst_grant got gid=%0d rd=%b exp gid=0 rd=1", bus.grant_id, bus.mem_rd);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if (bus.mem_rd !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0000 ||
          bus.rdata !== 16'h0 || bus.grant_id !== 3'd0) begin
         bad++;
         $display("FAIL midrst_clear got rd=%b busy=%b ack=%b rdata=%h gid=%0d exp all zero",
                  bus.mem_rd, bus.busy, bus.ack, bus.rdata, bus.grant_id);
      end
      ackSeen = bus.ack;
      for (int c = 0; c < 4; c++) begin
         tick();
         ackSeen |= bus.ack;
      end
      total++;
      if (ackSeen !== 4'b0000) begin
         bad++;
         $display("FAIL midrst_noack got ack_or=%b exp 0000", ackSeen);
      end
      bus.slot_en = 1'b1;
      tick();
      bus.slot_en = 1'b0;
      total++;
      if (bus.grant_id !== 3'd0 || bus.mem_rd !== 1'b1) begin
         bad++;
         $display("FAIL midrst_regrant got gid=%0d rd=%b exp gid=0 rd=1", bus.grant_id, bus.mem_rd);
      end
      tick();
      tick();
      total++;
      if (bus.ack !== 4'b0001 || bus.rdata !== 16'hCAFE) begin
         bad++;
         $display("FAIL midrst_ack got ack=%b rdata=%h exp ack=0001 rdata=cafe", bus.ack, bus.rdata);
      end
      tick();
      bus.req = '0;
   endtask

   initial begin
      reset = 1'b1;
      bus.slot_en = 1'b0;
      bus.req = '0;
      bus.req_addr = '0;
      bus.req_base = '0;
      bus.mem_din = '0;
      #1;
      test_reset();
      test_round_robin();
      test_wrap();
      test_overrun();
      test_withdrawal();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dio_slot_arbiter.md
# dio_slot_arbiter

Shares the disk/peripheral-I/O (DIO) RAM/ROM slot of the memory address controller among up to NREQ read requesters, such as the internal and external floppy image readers, a SCSI disk image reader and the ROM/image loader. On each DIO slot the block grants one pending requester in round-robin order. It drives the slot's memory address and read strobe, captures the returned 16-bit word and hands it back with a one-clock acknowledge. It sits between the requesters and the address controller's DIO path, and replaces fixed per-requester sub-slot assignment.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 22, memory word-address width
- RD_LAT, 2, clocks from slot start to valid read data (≥1)

Ports:
- clk  in  1  system clock (sole clock)
- reset  in  1  synchronous, active-high reset
- slot_en  in  1  single-clock pulse marking the start of a DIO slot
- req  in  NREQ  level request per requester; held with stable address until ack
- req_addr  in  NREQ*AW  per-requester address; requester i uses bits [i*AW +: AW]
- req_base  in  NREQ*AW  per-requester base offset (image placement in RAM)
- mem_din  in  16  read data from RAM/ROM
- mem_addr  out  AW  address driven during the slot
- mem_rd  out  1  read strobe (active high; the controller inverts it to produce OE)
- ack  out  NREQ  one-hot, one-clock acknowledge
- rdata  out  16  captured word, valid when any ack bit is high
- busy  out  1  arbiter not in IDLE
- grant_id  out  3  index of the current or last grantee
- overrun_cnt  out  8  slots missed while busy (saturating)

## Operation
- The state machine has three states: IDLE, ACCESS and ACK.
- **IDLE:**
  - If slot_en=1 and req≠0, choose grantee g as the first set req bit searching upward from (last+1) mod NREQ, wrapping around.
  - Register mem_addr = req_addr[g] + req_base[g], truncated mod 2^AW (wraps; no carry out).
  - Set mem_rd=1, load the latency counter with RD_LAT, update last=g and grant_id=g, then go to ACCESS.
  - If slot_en=1 and req=0, nothing happens and last is unchanged.
- **ACCESS:**
  - mem_addr and mem_rd are held.
  - The counter decrements each clock.
  - On the clock where the counter reaches 1, mem_din is sampled into rdata, mem_rd is cleared, and the state moves to ACK.
- **ACK:**
  - ack[g]=1 for exactly one clock, but only if req[g] is still high. If req[g] has dropped, no ack is issued and rdata is still updated.
  - The state then returns to IDLE.
- **Overrun:** slot_en seen in ACCESS or ACK increments overrun_cnt, which saturates at 255. The slot is ignored.
- **Fairness:** with all requesters permanently asserting, each is granted once per NREQ serviced slots.
- **Priority on reset:** last resets to NREQ-1, so requester 0 wins the first contention.
- **Request timing:** a request raised in the same clock as slot_en is eligible. req changes while busy do not affect the current grant.
- **Address stability:** req_addr and req_base are sampled only in the IDLE grant clock.
- **Reset:** reset at any time, including mid-ACCESS, forces the following values on the next edge, and any in-flight access is abandoned without ack:
  - state=IDLE
  - mem_addr=0, mem_rd=0
  - ack=0, rdata=0
  - busy=0, grant_id=0
  - overrun_cnt=0
  - last=NREQ-1

## Timing
- All outputs are registered.
- With slot_en at clock T:
  - mem_rd and mem_addr are valid during T+1..T+RD_LAT.
  - mem_din is sampled at the clock edge that ends cycle T+RD_LAT.
  - ack and rdata are valid in cycle T+RD_LAT+1.
  - busy is high during T+1..T+RD_LAT+1.
- The earliest next grant is at slot_en in cycle T+RD_LAT+2.
- Minimum slot_en spacing without overrun is RD_LAT+2 clocks; the address controller's 4-phase slot cadence satisfies this for RD_LAT≤2.
- A requester may drop req in the clock after ack and re-raise it with a new address in the same or any later clock.

## Test plan
- **Reset state:** reset, then release. Required: all outputs 0, busy=0. Then req=0001 with addr0=0x00010 and base0=0x100000, plus a slot_en pulse at T. Required: mem_addr=0x100010 and mem_rd=1 at T+1..T+2; mem_din=0xBEEF; ack=0001 and rdata=0xBEEF at T+3.
- **Round-robin:** req=1111 held, 8 slots. Required: grant_id sequence 0,1,2,3,0,1,2,3, with exactly one ack per slot.
- **Wrap-around:** base=0x3FFFF0 with addr=0x000020. Required: mem_addr=0x000010.
- **Overrun:** slot_en at T and again at T+2 (while busy). Required: second slot ignored, overrun_cnt=1; after 300 such overlaps, overrun_cnt=255.
- **Withdrawal:** req0 dropped at T+2 during ACCESS. Required: no ack at T+3, rdata still updated, next slot grants the next pending requester.
- **Reset mid-ACCESS:** reset at T+1. Required: mem_rd=0 and busy=0 next clock, no ack ever issued, and the next contended slot with req=1111 grants requester 0.
